// File: rtl/spi_master_rw.sv
// SPI master: parametrised word width, SCK divider, SPI mode and chip-select count.
// One word in flight; optional CS hold between consecutive words.
module spi_master_rw #(
   parameter int WIDTH = 8,
   parameter int DIV   = 8,
   parameter int NCS   = 1,
   parameter int CPOL  = 0,
   parameter int CPHA  = 0,
   localparam int SELW = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             write,
   input  logic             hold,
   input  logic [SELW-1:0]  cs_sel,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             busy,
   output logic             done,
   output logic [NCS-1:0]   cs,
   output logic             sck,
   output logic             mosi,
   input  logic             miso
);

   localparam int DCW = $clog2(DIV + 1);
   localparam int PCW = $clog2(2 * WIDTH + 2);

   typedef enum logic {ST_IDLE, ST_XFER} state_t;

   state_t             state_q, state_d;
   logic [DCW-1:0]     div_q, div_d;
   logic [PCW-1:0]     ph_q, ph_d, ph_nx;
   logic [WIDTH-1:0]   sh_q, sh_d;
   logic [WIDTH-1:0]   rx_q, rx_d;
   logic [WIDTH-1:0]   dout_q, dout_d;
   logic [NCS-1:0]     cs_q, cs_d;
   logic               sck_q, sck_d;
   logic               mosi_q, mosi_d;
   logic               done_q, done_d;
   logic               hold_q, hold_d;

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         ph_q    <= '0;
         sh_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         cs_q    <= '1;
         sck_q   <= 1'(CPOL);
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         ph_q    <= ph_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         cs_q    <= cs_d;
         sck_q   <= sck_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
      end
   end

   // Next-state logic: accept in idle, then phase/divider sequencing of SCK, MOSI and sampling.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      ph_d    = ph_q;
      sh_d    = sh_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      cs_d    = cs_q;
      sck_d   = sck_q;
      mosi_d  = mosi_q;
      done_d  = 1'b0;
      hold_d  = hold_q;
      ph_nx   = ph_q + PCW'(1);
      unique case (state_q)
         ST_IDLE: begin
            if (write) begin
               state_d = ST_XFER;
               div_d   = '0;
               ph_d    = '0;
               sh_d    = din;
               rx_d    = '0;
               hold_d  = hold;
               sck_d   = 1'(CPOL);
               // Re-deriving every line releases a hold on any other index.
               for (int unsigned i = 0; i < NCS; i++) begin
                  cs_d[i] = (cs_sel != SELW'(i));
               end
               if (CPHA == 0) begin
                  mosi_d = din[WIDTH-1];
               end
            end
         end
         ST_XFER: begin
            if (div_q == DCW'(DIV - 1)) begin
               div_d = '0;
               if (ph_q == PCW'(2 * WIDTH)) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  dout_d  = rx_q;
                  if (!hold_q) begin
                     cs_d = '1;
                  end
               end else begin
                  ph_d  = ph_nx;
                  sck_d = ~sck_q;
                  if (ph_nx[0]) begin
                     // Leading edge.
                     if (CPHA == 0) begin
                        rx_d = {rx_q[WIDTH-2:0], miso};
                     end else begin
                        mosi_d = sh_q[WIDTH-1];
                        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     // Trailing edge.
                     if (CPHA != 0) begin
                        rx_d = {rx_q[WIDTH-2:0], miso};
                     end else if (ph_nx != PCW'(2 * WIDTH)) begin
                        mosi_d = sh_q[WIDTH-2];
                        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                     end
                  end
               end
            end else begin
               div_d = div_q + DCW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q == ST_XFER);
   assign done = done_q;
   assign dout = dout_q;
   assign cs   = cs_q;
   assign sck  = sck_q;
   assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_master_rw.sv
// Bench for spi_master_rw: three instances (mode 0 / NCS=4, mode 3, WIDTH=16 DIV=1).
module tb_spi_master_rw;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- Instance A: WIDTH=8, DIV=2, NCS=4, mode 0, loopback
   logic       rstA_n = 1'b0, wrA = 1'b0, holdA = 1'b0;
   logic [1:0] selA = '0;
   logic [7:0] dinA = '0, doutA;
   logic       busyA, doneA, sckA, mosiA;
   logic [3:0] csA;

   spi_master_rw #(.WIDTH(8), .DIV(2), .NCS(4), .CPOL(0), .CPHA(0)) u_a (
      .clock(clk), .reset_n(rstA_n), .write(wrA), .hold(holdA), .cs_sel(selA),
      .din(dinA), .dout(doutA), .busy(busyA), .done(doneA), .cs(csA),
      .sck(sckA), .mosi(mosiA), .miso(mosiA));

   // ---------------- Instance B: WIDTH=8, DIV=2, NCS=1, mode 3, slave model
   logic       rstB_n = 1'b0, wrB = 1'b0, holdB = 1'b0, selB = 1'b0;
   logic [7:0] dinB = '0, doutB;
   logic       busyB, doneB, sckB, mosiB, misoB = 1'b0;
   logic [0:0] csB;

   spi_master_rw #(.WIDTH(8), .DIV(2), .NCS(1), .CPOL(1), .CPHA(1)) u_b (
      .clock(clk), .reset_n(rstB_n), .write(wrB), .hold(holdB), .cs_sel(selB),
      .din(dinB), .dout(doutB), .busy(busyB), .done(doneB), .cs(csB),
      .sck(sckB), .mosi(mosiB), .miso(misoB));

   // ---------------- Instance C: WIDTH=16, DIV=1, NCS=1, mode 0, loopback
   logic        rstC_n = 1'b0, wrC = 1'b0, holdC = 1'b0, selC = 1'b0;
   logic [15:0] dinC = '0, doutC;
   logic        busyC, doneC, sckC, mosiC;
   logic [0:0]  csC;

   spi_master_rw #(.WIDTH(16), .DIV(1), .NCS(1), .CPOL(0), .CPHA(0)) u_c (
      .clock(clk), .reset_n(rstC_n), .write(wrC), .hold(holdC), .cs_sel(selC),
      .din(dinC), .dout(doutC), .busy(busyC), .done(doneC), .cs(csC),
      .sck(sckC), .mosi(mosiC), .miso(mosiC));

   // Mode-3 slave: shifts out on falling (leading) edge, captures on rising (trailing).
   logic [7:0] patB = 8'h3C;
   logic [7:0] srxB = '0;
   int         sidxB = 7;
   always @(negedge sckB) begin
      if (busyB && sidxB >= 0) begin
         misoB = patB[sidxB];
         sidxB--;
      end
   end
   always @(posedge sckB) begin
      if (busyB === 1'b1) srxB = {srxB[6:0], mosiB};
   end

   // Scoreboard for A: expected received word pushed on write, popped on done.
   logic [7:0] qA[$];
   int unsigned bcA = 0, rcA = 0;
   logic        sckA_prev = 1'b0;
   always @(negedge clk) begin
      if (busyA === 1'b1) bcA++;
      if (sckA === 1'b1 && sckA_prev === 1'b0) rcA++;
      sckA_prev = sckA;
      if (doneA === 1'b1) begin
         if (qA.size() == 0) begin
            check("A unexpected done", 32'd1, 32'd0);
         end else begin
            check("A dout", 32'(doutA), 32'(qA.pop_front()));
         end
         check("A busy cycles", bcA, 32'd34);
         check("A sck rises", rcA, 32'd8);
         bcA = 0;
         rcA = 0;
      end
   end

   task automatic writeA(input logic [7:0] d, input logic h, input logic [1:0] s);
      wrA = 1'b1; dinA = d; holdA = h; selA = s;
      qA.push_back(d);
      @(posedge clk); #1;
      wrA = 1'b0;
   endtask

   task automatic waitA();
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (doneA) return;
      end
      check("A done timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [7:0] din;
      logic       hold;
      logic [1:0] sel;
      logic [3:0] cs_exp;
   } vecA_t;
   vecA_t vA[5];

   logic bad;
   int   cnt;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vA[0] = '{8'hA5, 1'b0, 2'd0, 4'b1110};
      vA[1] = '{8'h3C, 1'b0, 2'd1, 4'b1101};
      vA[2] = '{8'h00, 1'b0, 2'd2, 4'b1011};
      vA[3] = '{8'hFF, 1'b0, 2'd3, 4'b0111};
      vA[4] = '{8'h81, 1'b0, 2'd0, 4'b1110};

      repeat (3) @(posedge clk);
      #1;
      check("A rst cs",   32'(csA),   32'hF);
      check("A rst sck",  32'(sckA),  32'd0);
      check("A rst mosi", 32'(mosiA), 32'd0);
      check("A rst dout", 32'(doutA), 32'd0);
      check("A rst busy", 32'(busyA), 32'd0);
      check("A rst done", 32'(doneA), 32'd0);
      check("B rst sck",  32'(sckB),  32'd1);
      check("B rst cs",   32'(csB),   32'd1);
      rstA_n = 1'b1; rstB_n = 1'b1; rstC_n = 1'b1;
      @(posedge clk); #1;

      // Table-driven single words on A.
      for (int i = 0; i < 5; i++) begin
         writeA(vA[i].din, vA[i].hold, vA[i].sel);
         check("A busy after accept", 32'(busyA), 32'd1);
         check("A cs during", 32'(csA), 32'(vA[i].cs_exp));
         check("A mosi msb", 32'(mosiA), 32'(vA[i].din[7]));
         waitA();
         check("A cs at done", 32'(csA), 32'hF);
         check("A sck at done", 32'(sckA), 32'd0);
         @(posedge clk); #1;
      end

      // Hold across back-to-back words on cs[2].
      writeA(8'h9F, 1'b1, 2'd2);
      bad = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (csA !== 4'b1011) bad = 1'b1;
         if (doneA) break;
         @(posedge clk); #1;
      end
      check("A hold first done", 32'(doneA), 32'd1);
      writeA(8'h00, 1'b0, 2'd2);
      for (int n = 0; n < 200; n++) begin
         if (doneA) break;
         if (csA !== 4'b1011) bad = 1'b1;
         @(posedge clk); #1;
      end
      check("A hold second done", 32'(doneA), 32'd1);
      check("A hold cs continuous", 32'(bad), 32'd0);
      check("A hold released", 32'(csA), 32'hF);
      @(posedge clk); #1;

      // Hold on cs[1], then switch to cs[3].
      writeA(8'h5A, 1'b1, 2'd1);
      waitA();
      check("A held at done", 32'(csA), 32'b1101);
      repeat (3) begin @(posedge clk); #1; end
      check("A held idle cs", 32'(csA), 32'b1101);
      check("A held idle sck", 32'(sckA), 32'd0);
      writeA(8'hC3, 1'b0, 2'd3);
      check("A switch cs", 32'(csA), 32'b0111);
      waitA();
      check("A switch end cs", 32'(csA), 32'hF);
      @(posedge clk); #1;

      // Writes while busy are ignored.
      writeA(8'h5A, 1'b0, 2'd0);
      for (int k = 0; k < 8; k++) begin
         wrA = 1'b1; dinA = 8'hFF; selA = 2'd3; holdA = 1'b1;
         @(posedge clk); #1;
         wrA = 1'b0;
         @(posedge clk); #1;
      end
      check("A still busy", 32'(busyA), 32'd1);
      check("A cs unchanged", 32'(csA), 32'b1110);
      waitA();
      check("A ignore cs end", 32'(csA), 32'hF);
      repeat (40) @(posedge clk);
      #1;
      check("A queue drained", 32'(qA.size()), 32'd0);

      // Mode 3 on B.
      sidxB = 7; srxB = '0;
      wrB = 1'b1; dinB = 8'h5A; selB = 1'b0; holdB = 1'b0;
      @(posedge clk); #1;
      wrB = 1'b0;
      check("B cs asserted", 32'(csB), 32'd0);
      begin
         int unsigned bc, rc;
         logic prev;
         bc = 1; rc = 0; prev = sckB;
         for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (sckB && !prev) rc++;
            prev = sckB;
            if (doneB) break;
            bc++;
         end
         check("B done", 32'(doneB), 32'd1);
         check("B busy cycles", bc, 32'd34);
         check("B sck rises", rc, 32'd8);
      end
      check("B dout", 32'(doutB), 32'h3C);
      check("B slave rx", 32'(srxB), 32'h5A);
      check("B sck idle", 32'(sckB), 32'd1);
      check("B cs end", 32'(csB), 32'd1);
      @(posedge clk); #1;

      // cs_sel beyond NCS on B: no CS, transfer still completes.
      sidxB = 7;
      wrB = 1'b1; dinB = 8'h11; selB = 1'b1;
      @(posedge clk); #1;
      wrB = 1'b0;
      bad = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (csB !== 1'b1) bad = 1'b1;
         if (doneB) break;
         @(posedge clk); #1;
      end
      check("B oob done", 32'(doneB), 32'd1);
      check("B oob cs", 32'(bad), 32'd0);

      // Reset mid-transfer on C.
      wrC = 1'b1; dinC = 16'h1234;
      @(posedge clk); #1;
      wrC = 1'b0;
      check("C cs asserted", 32'(csC), 32'd0);
      repeat (10) begin @(posedge clk); #1; end
      rstC_n = 1'b0;
      @(posedge clk); #1;
      check("C abort cs", 32'(csC), 32'd1);
      check("C abort sck", 32'(sckC), 32'd0);
      check("C abort busy", 32'(busyC), 32'd0);
      check("C abort done", 32'(doneC), 32'd0);
      check("C abort dout", 32'(doutC), 32'd0);
      rstC_n = 1'b1;
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (doneC) cnt++;
      end
      check("C no done after abort", 32'(cnt), 32'd0);
      wrC = 1'b1; dinC = 16'hBEEF;
      @(posedge clk); #1;
      wrC = 1'b0;
      cnt = 1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk); #1;
         if (doneC) break;
         cnt++;
      end
      check("C done", 32'(doneC), 32'd1);
      check("C busy cycles", 32'(cnt), 32'd33);
      check("C dout", 32'(doutC), 32'hBEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master_rw.md
Name: spi_master_rw

Overview:
Parametrised SPI master for configuration flash and peripheral access. It is the successor to the fixed 8-bit, mode-0, single-CS shifter.
- Adds configurable word width, SCK divider, SPI mode (CPOL/CPHA) and multiple chip selects.
- Adds busy/done handshake, CS hold across words, and synchronous reset.
- Sits between a register/FIFO host interface and the external SPI pins; one word in flight at a time.

Parameters:
WIDTH, 8, bits per transfer word (>=2), shifted MSB first
DIV, 8, SCK half-period in clock cycles (>=1)
NCS, 1, number of chip-select outputs (>=1)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge

Ports:
clock  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous reset, active low
write  input  1  start a transfer; accepted only when busy=0
hold  input  1  sampled with write; 1 = keep CS asserted after this word
cs_sel  input  max(1,clog2(NCS))  chip select index, sampled with write
din  input  WIDTH  word to transmit, sampled with write
dout  output  WIDTH  last received word; valid from done pulse until next done
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at end of transfer
cs  output  NCS  active-low chip selects
sck  output  1  SPI clock
mosi  output  1  serial data out (registered)
miso  input  1  serial data in

Behaviour:
- Reset (reset_n=0 at a clock edge): cs=all 1, sck=CPOL, mosi=0, dout=0, busy=0, done=0, hold latch=0. Reset mid-transfer aborts immediately: no done pulse, dout not updated.
- Idle: sck=CPOL. cs is all 1, except cs[latched sel]=0 if the previous word had hold=1.
- Accept: write=1 with busy=0.
  - Next cycle: busy=1; cs[cs_sel]=0 and all other cs=1, so a hold on a different index is released in the same cycle.
  - din, hold and cs_sel are latched.
  - mosi=din[WIDTH-1] from that cycle for CPHA=0.
- write while busy=1: ignored, with no effect on any state.
- Timing: each phase is DIV cycles.
  - Phase 0 is CS setup; sck=CPOL.
  - Phases 1..2*WIDTH toggle sck at their start; odd phases are leading edges, even phases are trailing edges.
  - Then return to idle.
  - busy is high for exactly DIV*(2*WIDTH+1) cycles.
- CPHA=0:
  - MSB is presented on mosi at CS assertion.
  - miso is sampled into the shift register at each leading edge.
  - mosi advances to the next bit at each trailing edge except the last.
- CPHA=1:
  - mosi is updated at each leading edge, starting with the MSB at the first leading edge.
  - miso is sampled at each trailing edge.
- Sampling is from the registered miso at the edge cycle; no extra input synchroniser.
- End of transfer: on the cycle busy falls to 0, done=1 for one cycle and dout=received word.
  - sck is back at CPOL.
  - If latched hold=0, cs returns to all 1 in this cycle; if hold=1, cs stays asserted.
- Back-to-back: write may be asserted in the same cycle done=1 (busy=0). It is accepted, and the new transfer starts with no idle gap beyond the setup phase.
- Counters:
  - Divider counter width clog2(DIV+1), wraps at DIV-1.
  - Phase counter width clog2(2*WIDTH+2).
  - No overflow paths.
- cs_sel >= NCS: no cs line is asserted; the transfer still runs and done still pulses.
- Exactly WIDTH sck rising edges and WIDTH falling edges occur per transfer, for every mode.

Test Plan:
- WIDTH=8, DIV=2, mode 0, miso looped to mosi; write din=0xA5, hold=0 -> busy high 34 cycles; 8 sck rising edges; done pulses once; dout=0xA5; cs[0] low 34 cycles then high.
- Same setup, mode 3 (CPOL=1, CPHA=1), miso driven with pattern 0x3C by model -> sck idles 1; data sampled on rising (trailing) edges; dout=0x3C; mosi bits match 0x5A sent.
- NCS=4, hold=1 write 0x9F to cs_sel=2, then write 0x00 on the done cycle to cs_sel=2 with hold=0 -> cs[2] stays low continuously across both words; then goes high; other cs stay high throughout.
- Hold=1 on cs_sel=1, then next write to cs_sel=3 -> cs[1] deasserts in the same cycle cs[3] asserts.
- write pulsed repeatedly mid-transfer with din=0xFF -> ignored; original word completes unchanged; single done.
- WIDTH=16, DIV=1: reset_n low at phase 10 -> next cycle cs=all 1, sck=CPOL, busy=0, no done; a new write afterwards completes normally in 33 cycles.
